// File: rtl/data_bus_responder.sv
// Data-side bus responder: a byte-writable RAM window plus a 16-byte timer/fault register block.
// Reads are combinational. Misses, misaligned accesses and bad MMIO writes set a sticky fault.
module data_bus_responder #(
    parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFF20_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] DwReadData,
    output logic        oFault,
    output logic        oIrq
);
    localparam int unsigned IDX_W    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [32:0] RAM_END  = {1'b0, RAM_BASE} + 33'(4 * RAM_WORDS);
    localparam logic [32:0] MMIO_END = {1'b0, MMIO_BASE} + 33'd16;

    typedef enum logic [1:0] {
        REG_COUNT = 2'd0,
        REG_CMP   = 2'd1,
        REG_CTRL  = 2'd2,
        REG_FADDR = 2'd3
    } mmio_reg_e;

    logic [31:0]      ram_q [RAM_WORDS];
    logic [31:0]      count_q, count_d;
    logic [31:0]      cmp_q, cmp_d;
    logic [31:0]      faultAddr_q, faultAddr_d;
    logic             en_q, en_d;
    logic             pend_q, pend_d;
    logic             fault_q, fault_d;

    logic [IDX_W-1:0] ramIndex;
    mmio_reg_e        mmioSel;
    logic             ramHit, mmioHit, miss;
    logic             misaligned, realAccess, mmioPartial;
    logic             faultEvent, ramWrite, mmioWrite;
    logic [31:0]      readData;

    assign ramIndex = IDX_W'((DwAddress - RAM_BASE) >> 2);
    assign mmioSel  = mmio_reg_e'(2'((DwAddress - MMIO_BASE) >> 2));

    assign ramHit  = ({1'b0, DwAddress} >= {1'b0, RAM_BASE})  && ({1'b0, DwAddress} < RAM_END);
    assign mmioHit = ({1'b0, DwAddress} >= {1'b0, MMIO_BASE}) && ({1'b0, DwAddress} < MMIO_END);
    assign miss    = !ramHit && !mmioHit;

    assign misaligned = ((DwByteEnable == 4'b1111) && (DwAddress[1:0] != 2'b00)) ||
                        (((DwByteEnable == 4'b0011) || (DwByteEnable == 4'b1100)) && DwAddress[0]);

    // An empty-lane write with no read is a true no-op: it neither writes nor faults.
    assign realAccess  = DwReadEnable || (DwWriteEnable && (DwByteEnable != 4'b0000));
    assign mmioPartial = DwWriteEnable && mmioHit &&
                         (DwByteEnable != 4'b1111) && (DwByteEnable != 4'b0000);
    assign faultEvent  = (realAccess && (miss || misaligned)) || mmioPartial;

    assign ramWrite  = DwWriteEnable && ramHit && !misaligned && (DwByteEnable != 4'b0000);
    assign mmioWrite = DwWriteEnable && mmioHit && !misaligned && (DwByteEnable == 4'b1111);

    always_comb begin
        readData = '0;
        if (DwReadEnable && !misaligned) begin
            if (ramHit) begin
                readData = ram_q[ramIndex];
            end else if (mmioHit) begin
                case (mmioSel)
                    REG_COUNT: readData = count_q;
                    REG_CMP:   readData = cmp_q;
                    REG_CTRL:  readData = {29'd0, fault_q, pend_q, en_q};
                    REG_FADDR: readData = faultAddr_q;
                    default:   readData = '0;
                endcase
            end
        end
    end

    assign DwReadData = readData;

    always_comb begin
        count_d     = en_q ? count_q + 32'd1 : count_q;
        cmp_d       = cmp_q;
        en_d        = en_q;
        pend_d      = pend_q;
        fault_d     = fault_q;
        faultAddr_d = faultAddr_q;

        if (mmioWrite) begin
            case (mmioSel)
                REG_COUNT: count_d = DwWriteData;
                REG_CMP:   cmp_d   = DwWriteData;
                REG_CTRL: begin
                    en_d = DwWriteData[0];
                    if (DwWriteData[1]) pend_d  = 1'b0;
                    if (DwWriteData[2]) fault_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Setting events are applied last so they win over a same-edge write-1-clear.
        if (en_q && (count_q == cmp_q)) begin
            pend_d = 1'b1;
        end
        if (faultEvent) begin
            fault_d = 1'b1;
            if (!fault_q) faultAddr_d = DwAddress;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count_q     <= '0;
            cmp_q       <= '0;
            faultAddr_q <= '0;
            en_q        <= 1'b0;
            pend_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            cmp_q       <= cmp_d;
            faultAddr_q <= faultAddr_d;
            en_q        <= en_d;
            pend_q      <= pend_d;
            fault_q     <= fault_d;
        end
    end

    // RAM keeps its contents through reset; writes attempted during reset are dropped.
    always_ff @(posedge iCLK) begin
        if (!iRST && ramWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (DwByteEnable[b]) ram_q[ramIndex][8*b +: 8] <= DwWriteData[8*b +: 8];
            end
        end
    end

    assign oFault = fault_q;
    assign oIrq   = pend_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: expected read values are queued as stimulus is
// issued and popped when the combinational read data is sampled.
module tb_data_bus_responder;
    localparam logic [31:0] RB      = 32'h1001_0000;
    localparam logic [31:0] MB      = 32'hFF20_0000;
    localparam logic [31:0] A_COUNT = MB;
    localparam logic [31:0] A_CMP   = MB + 32'd4;
    localparam logic [31:0] A_CTRL  = MB + 32'd8;
    localparam logic [31:0] A_FADDR = MB + 32'd12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        re = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0, wd = '0;
    logic [31:0] rdata;
    logic        fault, irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ [$];
    string       tagQ [$];

    data_bus_responder dut (
        .iCLK         (clk),
        .iRST         (rst),
        .DwReadEnable (re),
        .DwWriteEnable(we),
        .DwByteEnable (be),
        .DwAddress    (addr),
        .DwWriteData  (wd),
        .DwReadData   (rdata),
        .oFault       (fault),
        .oIrq         (irq)
    );

    always #5 clk = ~clk;

    task automatic idleBus();
        re = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wd = '0;
    endtask

    // Each bus operation occupies exactly one rising edge and returns 1 time unit after it.
    task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        re = 1'b0; we = 1'b1; be = b; addr = a; wd = d;
        @(posedge clk);
        #1 idleBus();
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        re = 1'b1; we = 1'b0; be = 4'hF; addr = a;
        #1 d = rdata;
        @(posedge clk);
        #1 idleBus();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectRead(input logic [31:0] v, input string tag);
        expQ.push_back(v);
        tagQ.push_back(tag);
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        string tag;
        logic [31:0] regs [4];
        regs = '{A_COUNT, A_CMP, A_CTRL, A_FADDR};
        #1 rst = 1'b1;
        #1;
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: oFault=%b expected 0", fault); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: oIrq=%b expected 0", irq); end
        re = 1'b1; be = 4'hF; addr = A_COUNT;
        #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_count_async: read %h expected 0", rdata); end
        idleBus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) expectRead(32'd0, $sformatf("reset_reg%0d", i));
        for (int i = 0; i < 4; i++) begin
            busRead(regs[i], got);
            exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        end
    endtask

    task automatic test_ram_bytelanes();
        logic [31:0] got, exp;
        string tag;
        logic [31:0] addrs [2];
        addrs = '{RB + 32'h8, RB + 32'h3FC};
        busWrite(RB + 32'h8, 32'hDEAD_BEEF, 4'b1111);
        busWrite(RB + 32'h8, 32'h0000_00AA, 4'b0001);
        busWrite(RB + 32'h8, 32'hFFFF_FFFF, 4'b0000);
        expectRead(32'hDEAD_BEAA, "ram_lane0_merge");
        busWrite(RB + 32'h3FC, 32'hCAFE_F00D, 4'b1111);
        busWrite(RB + 32'h3FE, 32'h5A5A_0000, 4'b1100);
        expectRead(32'h5A5A_F00D, "ram_top_halfword");
        for (int i = 0; i < 2; i++) begin
            busRead(addrs[i], got);
            exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL ram_no_fault: oFault=%b expected 0", fault); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        string tag;
        busWrite(RB + 32'h10, 32'h1111_1111, 4'b1111);
        expectRead(32'h1111_1111, "rw_same_cycle_old");
        @(negedge clk);
        re = 1'b1; we = 1'b1; be = 4'hF; addr = RB + 32'h10; wd = 32'h2222_2222;
        #1 got = rdata;
        exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        @(posedge clk);
        #1 idleBus();
        addr = RB + 32'h10; be = 4'hF;
        #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL read_disabled_zero: read %h expected 0", rdata); end
        idleBus();
        expectRead(32'h2222_2222, "rw_same_cycle_new");
        busRead(RB + 32'h10, got);
        exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
    endtask

    task automatic test_miss_fault();
        logic [31:0] got, exp;
        string tag;
        logic [31:0] addrs [8];
        addrs = '{32'h0, 32'h4, A_FADDR, RB + 32'h400, A_FADDR, 32'h8, A_FADDR, A_CTRL};
        expectRead(32'd0, "miss_read0");
        expectRead(32'd0, "miss_read4");
        expectRead(32'd0, "faultaddr_first");
        for (int i = 0; i < 3; i++) begin
            busRead(addrs[i], got);
            exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
            if (i == 0) begin
                checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL miss_fault_set: oFault=%b expected 1", fault); end
            end
        end
        busWrite(A_CTRL, 32'h4, 4'b1111);
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_w1c: oFault=%b expected 0", fault); end
        expectRead(32'd0, "miss_past_ram_end");
        expectRead(RB + 32'h400, "faultaddr_past_end");
        expectRead(32'd0, "miss_read8");
        expectRead(RB + 32'h400, "faultaddr_sticky");
        expectRead(32'h0000_0004, "ctrl_shows_fault");
        for (int i = 3; i < 8; i++) begin
            busRead(addrs[i], got);
            exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        end
        busWrite(A_CTRL, 32'h4, 4'b1111);
    endtask

    task automatic test_misaligned();
        logic [31:0] got, exp;
        string tag;
        logic [31:0] addrs [3];
        addrs = '{RB, A_FADDR, RB + 32'h1};
        busWrite(RB, 32'h0123_4567, 4'b1111);
        busWrite(RB + 32'h2, 32'hFFFF_FFFF, 4'b1111);
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_fault: oFault=%b expected 1", fault); end
        expectRead(32'h0123_4567, "misaligned_word_kept");
        expectRead(RB + 32'h2, "misaligned_faultaddr");
        expectRead(32'd0, "misaligned_read_zero");
        for (int i = 0; i < 3; i++) begin
            busRead(addrs[i], got);
            exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        end
        busWrite(A_CTRL, 32'h4, 4'b1111);
        busWrite(RB + 32'h1, 32'h0000_FFFF, 4'b0011);
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_half_fault: oFault=%b expected 1", fault); end
        expectRead(32'h0123_4567, "misaligned_half_kept");
        busRead(RB, got);
        exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        busWrite(A_CTRL, 32'h4, 4'b1111);
    endtask

    task automatic test_mmio_partial();
        logic [31:0] got, exp;
        string tag;
        logic [31:0] addrs [4];
        addrs = '{A_CMP, A_FADDR, A_FADDR, A_CTRL};
        busWrite(A_CMP, 32'h55, 4'b1111);
        busWrite(A_CMP, 32'hAA, 4'b0011);
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL mmio_partial_fault: oFault=%b expected 1", fault); end
        expectRead(32'h55, "mmio_partial_ignored");
        expectRead(A_CMP, "mmio_partial_faultaddr");
        for (int i = 0; i < 2; i++) begin
            busRead(addrs[i], got);
            exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        end
        busWrite(A_CTRL, 32'h4, 4'b1111);
        busWrite(A_FADDR, 32'h1234, 4'b1111);
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL faultaddr_write_no_fault: oFault=%b expected 0", fault); end
        expectRead(A_CMP, "faultaddr_readonly");
        expectRead(32'd0, "ctrl_idle");
        for (int i = 2; i < 4; i++) begin
            busRead(addrs[i], got);
            exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        end
    endtask

    task automatic test_timer();
        logic [31:0] got, exp;
        string tag;
        busWrite(A_COUNT, 32'hFFFF_FFFE, 4'b1111);
        busWrite(A_CMP, 32'h1, 4'b1111);
        busWrite(A_CTRL, 32'h1, 4'b1111);
        expectRead(32'hFFFF_FFFE, "count_loaded");
        expectRead(32'hFFFF_FFFF, "count_ffffffff");
        expectRead(32'h0, "count_wrap");
        expectRead(32'h1, "count_one");
        for (int i = 0; i < 4; i++) begin
            busRead(A_COUNT, got);
            exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
            if (i == 2) begin
                checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_before_match: oIrq=%b expected 0", irq); end
            end
        end
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_after_match: oIrq=%b expected 1", irq); end
        expectRead(32'h3, "ctrl_en_pend");
        busRead(A_CTRL, got);
        exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        busWrite(A_CMP, 32'h5, 4'b1111);
        tick();
        busWrite(A_CTRL, 32'h3, 4'b1111);
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL pend_set_beats_w1c: oIrq=%b expected 1", irq); end
        busWrite(A_CTRL, 32'h3, 4'b1111);
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL pend_w1c: oIrq=%b expected 0", irq); end
        expectRead(32'h7, "count_after_w1c");
        busRead(A_COUNT, got);
        exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] got, exp;
        string tag;
        logic [31:0] addrs [3];
        addrs = '{RB + 32'h20, A_COUNT, A_CTRL};
        busWrite(RB + 32'h20, 32'h1111_2222, 4'b1111);
        busWrite(A_COUNT, 32'h10, 4'b1111);
        busWrite(A_CMP, 32'h11, 4'b1111);
        expectRead(32'd0, "miss_before_reset");
        busRead(32'h0, got);
        exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_before_reset: oIrq=%b expected 1", irq); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_before_reset: oFault=%b expected 1", fault); end
        #2 rst = 1'b1;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_irq: oIrq=%b expected 0", irq); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_fault: oFault=%b expected 0", fault); end
        re = 1'b1; be = 4'hF; addr = A_COUNT;
        #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_count: read %h expected 0", rdata); end
        idleBus();
        @(negedge clk);
        we = 1'b1; be = 4'hF; addr = RB + 32'h20; wd = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 idleBus();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) tick();
        expectRead(32'h1111_2222, "ram_survives_reset");
        expectRead(32'd0, "count_stays_zero");
        expectRead(32'd0, "ctrl_disabled");
        for (int i = 0; i < 3; i++) begin
            busRead(addrs[i], got);
            exp = expQ.pop_front(); tag = tagQ.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s: read %h expected %h", tag, got, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_ram_bytelanes();
        test_back_to_back();
        test_miss_fault();
        test_misaligned();
        test_mmio_partial();
        test_timer();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter RAM_BASE, default 32'h1001_0000, meaning byte base address of the data RAM window.
REQ-002 SHALL have parameter RAM_WORDS, default 256, meaning RAM depth in 32-bit words (power of two).
REQ-003 SHALL have parameter MMIO_BASE, default 32'hFF20_0000, meaning byte base address of the 16-byte register window.
REQ-004 iCLK  input  1  single clock; all state updates on its rising edge.
REQ-005 iRST  input  1  reset, asynchronous, active-high.
REQ-006 DwReadEnable  input  1  read request from the datapath.
REQ-007 DwWriteEnable  input  1  write request from the datapath.
REQ-008 DwByteEnable  input  4  byte-lane enables; bit n selects bits [8n+7:8n].
REQ-009 DwAddress  input  32  byte address.
REQ-010 DwWriteData  input  32  write data.
REQ-011 DwReadData  output  32  read data, combinational, same cycle as request.
REQ-012 oFault  output  1  sticky access-fault flag.
REQ-013 oIrq  output  1  timer interrupt request, level.

Function
REQ-014 Access decode: RAM hit when RAM_BASE <= DwAddress < RAM_BASE+4*RAM_WORDS; MMIO hit when MMIO_BASE <= DwAddress < MMIO_BASE+16; otherwise miss.
REQ-015 RAM read: DwReadData = word at (DwAddress-RAM_BASE)>>2, all 32 bits returned regardless of DwByteEnable; zero-latency.
REQ-016 RAM write: on rising edge with DwWriteEnable=1 and RAM hit, only enabled lanes updated; disabled lanes keep prior value.
REQ-017 DwByteEnable=0000 with DwWriteEnable=1 SHALL change no state and raise no fault.
REQ-018 Misaligned access (DwByteEnable=1111 with DwAddress[1:0]!=0, or 0011/1100 with DwAddress[0]=1) SHALL suppress the write, return 0 on read, and set the fault flag.
REQ-019 Miss with DwReadEnable or DwWriteEnable high SHALL return 0, suppress write, set the fault flag.
REQ-020 Fault flag (oFault) sticky; captures DwAddress into FAULTADDR only on first fault after clear.
REQ-021 DwReadEnable and DwWriteEnable both high: write performed at the edge; DwReadData shows pre-write contents that cycle.
REQ-022 DwReadData = 0 whenever DwReadEnable=0.
REQ-023 MMIO offset 0x0 COUNT: 32-bit counter, +1 per cycle when CTRL.en=1, wraps 32'hFFFF_FFFF -> 0; a write loads DwWriteData (full word only) and overrides the increment that cycle.
REQ-024 MMIO offset 0x4 CMP: read/write compare value.
REQ-025 MMIO offset 0x8 CTRL: bit0 en (RW), bit1 pend (read; write-1-clears), bit2 fault (read; write-1-clears oFault), bits[31:3] read 0.
REQ-026 pend SHALL set on the edge where CTRL.en=1 and COUNT==CMP (pre-increment value); set wins over a simultaneous W1C.
REQ-027 oIrq = pend; one cycle after the setting edge it is visible, no extra latency.
REQ-028 MMIO offset 0xC FAULTADDR: read-only; writes ignored without fault.
REQ-029 MMIO partial-width writes (DwByteEnable != 1111) SHALL be ignored and set the fault flag.

Reset
REQ-030 iRST=1 SHALL immediately force COUNT=0, CMP=0, CTRL=0, pend=0, oFault=0, oIrq=0, FAULTADDR=0, independent of iCLK.
REQ-031 RAM contents SHALL NOT be reset; writes requested while iRST=1 SHALL be discarded.
REQ-032 Reset asserted mid-count SHALL leave the counter at 0 and disabled after release.

Verification
REQ-033 Write 32'hDEADBEEF to RAM_BASE+8 with BE=1111, then write 32'h000000AA with BE=0001 -> read RAM_BASE+8 returns 32'hDEADBEAA, oFault=0.
REQ-034 Read address 32'h0000_0000 -> DwReadData=0, oFault=1 next cycle, FAULTADDR=0; second miss at 32'h4 keeps FAULTADDR=0; write 32'h4 to CTRL clears oFault.
REQ-035 Write BE=1111 at RAM_BASE+2 -> RAM word unchanged, oFault=1, FAULTADDR=RAM_BASE+2.
REQ-036 Write COUNT=32'hFFFF_FFFE, CMP=32'h0000_0001, CTRL=1 -> COUNT reads FFFF_FFFF, 0, 1; oIrq rises the cycle after COUNT==1 edge; W1C of pend on the same edge as a new match keeps oIrq=1.
REQ-037 Assert iRST between clock edges while CTRL.en=1 and oIrq=1 -> oIrq, oFault, COUNT read 0 without waiting for iCLK; previously written RAM word still reads back.
